siren_driver: RTL and testbench



---
 rtl/siren_driver_pkg.sv | 20 ++
 rtl/siren_driver_cycle_timer.sv | 34 +++
 rtl/siren_driver.sv | 137 +++++++++++++
 tb/tb_siren_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/siren_driver_pkg.sv
// Shared types and widths for the siren driver: FSM state encoding and counter widths.
package siren_driver_pkg;

  localparam int unsigned CntW = 16;
  localparam int unsigned EvtW = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StChirp  = 3'd1,
    StWarn   = 3'd2,
    StSound  = 3'd3,
    StCutoff = 3'd4
  } state_e;

  // Terminal compare value for a duration of len cycles (counter starts at 0 on entry).
  function automatic logic [CntW-1:0] term_of(input int unsigned len);
    return CntW'(len - 1);
  endfunction

endpackage

// File: rtl/siren_driver_cycle_timer.sv
// Loadable up-counter with terminal compare; holds at the terminal value instead of wrapping.
module siren_driver_cycle_timer
  import siren_driver_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [CntW-1:0] term_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !done_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/siren_driver.sv
// Annunciator driver: arm chirp, pulsed entry-delay beeper, time-limited siren with cutoff,
// and a saturating alarm event counter. All outputs are registered.
module siren_driver
  import siren_driver_pkg::*;
#(
  parameter int unsigned CHIRP_LEN = 4,
  parameter int unsigned BEEP_HALF = 5,
  parameter int unsigned SIREN_MAX = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_armed,
  input  logic       is_wait_delay,
  input  logic       alarm_siren,
  output logic       siren_out,
  output logic       beeper_out,
  output logic       cutoff,
  output logic [7:0] event_count
);

  localparam logic [CntW-1:0] ChirpTerm = term_of(CHIRP_LEN);
  localparam logic [CntW-1:0] BeepTerm  = term_of(BEEP_HALF);
  localparam logic [CntW-1:0] SirenTerm = term_of(SIREN_MAX);

  state_e          state_q, state_d;
  logic            armed_q;
  logic            phase_q, phase_d;
  logic            siren_q, siren_d;
  logic            beeper_q, beeper_d;
  logic            cutoff_q, cutoff_d;
  logic [EvtW-1:0] event_q, event_d;

  logic            arm_rise;
  logic            enter;
  logic            warn_wrap;
  logic            tmr_clear;
  logic            tmr_en;
  logic            tmr_done;
  logic [CntW-1:0] tmr_term;

  assign arm_rise = is_armed & ~armed_q;

  always_comb begin
    tmr_term = '0;
    unique case (state_q)
      StChirp: tmr_term = ChirpTerm;
      StWarn:  tmr_term = BeepTerm;
      StSound: tmr_term = SirenTerm;
      default: tmr_term = '0;
    endcase
  end

  // Priority alarm > entry delay > arm edge everywhere except CUTOFF, which only
  // waits for the alarm request to drop. An arm edge during CHIRP restarts it.
  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    if (state_q == StCutoff) begin
      if (!alarm_siren) state_d = StIdle;
    end else if (alarm_siren) begin
      if (state_q != StSound) begin
        state_d = StSound;
        enter   = 1'b1;
      end else if (tmr_done) begin
        state_d = StCutoff;
      end
    end else if (is_wait_delay) begin
      if (state_q != StWarn) begin
        state_d = StWarn;
        enter   = 1'b1;
      end
    end else if (arm_rise) begin
      state_d = StChirp;
      enter   = 1'b1;
    end else if (!(state_q == StChirp && !tmr_done)) begin
      state_d = StIdle;
    end
  end

  assign warn_wrap = (state_q == StWarn) && (state_d == StWarn) && tmr_done;
  assign tmr_clear = enter | warn_wrap;
  assign tmr_en    = (state_d == state_q);

  always_comb begin
    phase_d = phase_q;
    if (enter) begin
      phase_d = 1'b0;
    end else if (warn_wrap) begin
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    siren_d  = (state_d == StSound);
    cutoff_d = (state_d == StCutoff);
    beeper_d = (state_d == StChirp) || ((state_d == StWarn) && !phase_d);
    event_d  = event_q;
    if (enter && (state_d == StSound) && (event_q != '1)) begin
      event_d = event_q + EvtW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      armed_q  <= is_armed;
      phase_q  <= 1'b0;
      siren_q  <= 1'b0;
      beeper_q <= 1'b0;
      cutoff_q <= 1'b0;
      event_q  <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= is_armed;
      phase_q  <= phase_d;
      siren_q  <= siren_d;
      beeper_q <= beeper_d;
      cutoff_q <= cutoff_d;
      event_q  <= event_d;
    end
  end

  siren_driver_cycle_timer u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .term_i   (tmr_term),
    .done_o   (tmr_done)
  );

  assign siren_out   = siren_q;
  assign beeper_out  = beeper_q;
  assign cutoff      = cutoff_q;
  assign event_count = event_q;

endmodule

// File: tb/tb_siren_driver.sv
// Randomized bench for siren_driver against a mode/elapsed-time reference model.
module tb_siren_driver;

  localparam int CHIRP_LEN = 4;
  localparam int BEEP_HALF = 5;
  localparam int SIREN_MAX = 64;

  localparam int M_IDLE  = 0;
  localparam int M_CHIRP = 1;
  localparam int M_WARN  = 2;
  localparam int M_SOUND = 3;
  localparam int M_CUT   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       is_armed = 1'b0;
  logic       is_wait_delay = 1'b0;
  logic       alarm_siren = 1'b0;
  logic       siren_out;
  logic       beeper_out;
  logic       cutoff;
  logic [7:0] event_count;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: current mode and cycles spent in it (1 on the first cycle).
  int m_mode = M_IDLE;
  int m_el   = 0;
  int m_evt  = 0;
  bit m_prev = 1'b0;

  int beep_hi  = 0;
  int siren_hi = 0;

  siren_driver #(
    .CHIRP_LEN (CHIRP_LEN),
    .BEEP_HALF (BEEP_HALF),
    .SIREN_MAX (SIREN_MAX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .is_armed      (is_armed),
    .is_wait_delay (is_wait_delay),
    .alarm_siren   (alarm_siren),
    .siren_out     (siren_out),
    .beeper_out    (beeper_out),
    .cutoff        (cutoff),
    .event_count   (event_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit arm, input bit wd, input bit al);
    bit rise;
    if (rst) begin
      m_mode = M_IDLE;
      m_el   = 0;
      m_evt  = 0;
      m_prev = arm;
      return;
    end
    rise   = arm && !m_prev;
    m_prev = arm;
    if (m_mode == M_CUT) begin
      if (!al) m_mode = M_IDLE;
    end else if (al) begin
      if (m_mode != M_SOUND) begin
        m_mode = M_SOUND;
        m_el   = 1;
        if (m_evt < 255) m_evt++;
      end else if (m_el >= SIREN_MAX) begin
        m_mode = M_CUT;
      end else begin
        m_el++;
      end
    end else if (wd) begin
      if (m_mode != M_WARN) begin
        m_mode = M_WARN;
        m_el   = 1;
      end else begin
        m_el++;
      end
    end else if (rise) begin
      m_mode = M_CHIRP;
      m_el   = 1;
    end else if (m_mode == M_CHIRP && m_el < CHIRP_LEN) begin
      m_el++;
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic tick(input bit rst, input bit arm, input bit wd, input bit al);
    int exp_beep;
    reset         = rst;
    is_armed      = arm;
    is_wait_delay = wd;
    alarm_siren   = al;
    @(posedge clk);
    model_step(rst, arm, wd, al);
    #1;
    exp_beep = (m_mode == M_CHIRP) ||
               (m_mode == M_WARN && (((m_el - 1) / BEEP_HALF) % 2) == 0);
    check_eq("siren_out", int'(siren_out), int'(m_mode == M_SOUND));
    check_eq("beeper_out", int'(beeper_out), exp_beep);
    check_eq("cutoff", int'(cutoff), int'(m_mode == M_CUT));
    check_eq("event_count", int'(event_count), m_evt);
    check_eq("no_overlap", int'(siren_out & beeper_out), 0);
    beep_hi  += int'(beeper_out);
    siren_hi += int'(siren_out);
  endtask

  initial begin
    bit a, w, r, rst;

    // Reset while armed, then release: no chirp.
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    beep_hi = 0;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("no_chirp_after_reset", beep_hi, 0);

    // Arm edge: chirp of CHIRP_LEN cycles.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    beep_hi = 0;
    siren_hi = 0;
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("chirp_len", beep_hi, CHIRP_LEN);
    check_eq("chirp_no_siren", siren_hi, 0);

    // Entry delay for 30 cycles: 3 periods of 5 high / 5 low.
    beep_hi = 0;
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("warn_high_cycles", beep_hi, 15);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("warn_off_after_drop", int'(beeper_out), 0);

    // Alarm held 100 cycles: siren SIREN_MAX cycles then cutoff.
    siren_hi = 0;
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("siren_len", siren_hi, SIREN_MAX);
    check_eq("cutoff_held", int'(cutoff), 1);
    check_eq("event_one", int'(event_count), 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("cutoff_cleared", int'(cutoff), 0);

    // Entry delay and alarm together, then reset mid-sound.
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("both_sound", int'(siren_out), 1);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("reset_siren", int'(siren_out), 0);
    check_eq("reset_events", int'(event_count), 0);

    // 256 short alarm pulses: count saturates at 255.
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("event_saturate", int'(event_count), 255);
    tick(1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic with long-ish holds so every state gets exercised.
    a = 1'b0; w = 1'b0; r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) a = ~a;
      if ($urandom_range(15) == 0) w = ~w;
      if ($urandom_range(9) == 0)  r = ~r;
      rst = ($urandom_range(399) == 0);
      tick(rst, r, w, a);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
